core_dispatch_scoreboard: RTL and testbench

Tracks in-flight register writes and execution-unit occupancy for the dual-issue dispatch stage. It produces the pending-write mask and structural-busy flags that the dispatch hazard check consumes. It also sequences the non-pipelined multiplier with a fixed-latency countdown. Sits between dispatch (set side) and the EU writeback ports (clear side).

---
 rtl/core_dispatch_scoreboard_pkg.sv | 27 ++
 rtl/core_dispatch_scoreboard_cnt.sv | 74 +++++++
 rtl/core_dispatch_scoreboard.sv | 155 +++++++++++++++
 tb/tb_core_dispatch_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_dispatch_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_scoreboard_pkg
//  Brief    : Shared uarch types for the dispatch scoreboard: EU class enum,
//             register-number and half-word mask types, default latencies.
//  Revision : 1.0 - initial release
// ============================================================================
package core_dispatch_scoreboard_pkg;

  localparam int unsigned c_NUM_REGS    = 16;
  localparam int unsigned c_RD_W        = 4;
  localparam int unsigned c_MUL_LATENCY = 3;
  localparam int unsigned c_CNT_W       = 2;

  // Execution-unit class carried with every dispatched instruction
  typedef enum logic [1:0] {
    EU_ALU    = 2'd0,
    EU_MUL    = 2'd1,
    EU_LDST   = 2'd2,
    EU_BRANCH = 2'd3
  } eu_class_e;

  typedef logic [c_RD_W-1:0]     reg_num_t;
  typedef logic [c_NUM_REGS-1:0] hword_t;

endpackage
`default_nettype wire

// File: rtl/core_dispatch_scoreboard_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_scoreboard_cnt
//  Brief    : Pending-write counter for one architectural register. Adds up
//             to two sets and subtracts up to four clears per cycle, clamping
//             at 0 and at the counter maximum.
//  Options  : CORE_SB_BYPASS_EN - busy drops combinationally when the last
//             outstanding write is being cleared this cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module core_dispatch_scoreboard_cnt
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = c_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] set_cnt,
  input  logic [2:0] clr_cnt,
  output logic       busy,
  output logic       sat
);

  // Two extra bits hold cnt + 2 sets and up to four clears without wrap
  localparam int unsigned      c_SUM_W  = CNT_W + 2;
  localparam logic [CNT_W-1:0] c_MAX    = '1;
  localparam logic [CNT_W-1:0] c_SAT_TH = c_MAX - CNT_W'(1);

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [c_SUM_W-1:0] w_up;
  logic [c_SUM_W-1:0] w_clr;
  logic [c_SUM_W-1:0] w_net;

  // Net the sets and clears, clamping both ends of the range
  always_comb begin
    w_up  = c_SUM_W'(r_cnt) + c_SUM_W'(set_cnt);
    w_clr = c_SUM_W'(clr_cnt);
    w_net = w_up - w_clr;
    if (w_clr > w_up) begin
      w_cnt_nxt = '0;
    end else if (w_net > c_SUM_W'(c_MAX)) begin
      w_cnt_nxt = c_MAX;
    end else begin
      w_cnt_nxt = CNT_W'(w_net);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Pending flag, optionally bypassing the final clear
  always_comb begin
`ifdef CORE_SB_BYPASS_EN
    busy = (r_cnt != '0) && !((r_cnt == CNT_W'(1)) && (clr_cnt != 3'd0));
`else
    busy = (r_cnt != '0);
`endif
    sat = (r_cnt >= c_SAT_TH);
  end

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    w_clr <= w_up);
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    (w_clr > w_up) || (w_net <= c_SUM_W'(c_MAX)));

endmodule
`default_nettype wire

// File: rtl/core_dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : core_dispatch_scoreboard
//  Brief    : Dual-issue dispatch scoreboard. Tracks pending register writes
//             per register, sequences the non-pipelined multiplier with a
//             fixed-latency countdown, and latches the ldst destination.
//  Options  : CORE_SB_BYPASS_EN - mask_wr clears in the writeback cycle
//             (forwarded into every per-register counter).
//  Revision : 1.0 - initial release
// ============================================================================
module core_dispatch_scoreboard
  import core_dispatch_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS    = c_NUM_REGS,
  parameter int unsigned RD_W        = c_RD_W,
  parameter int unsigned MUL_LATENCY = c_MUL_LATENCY,
  parameter int unsigned CNT_W       = c_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                disp_a_valid,
  input  logic                disp_a_wb,
  input  logic [RD_W-1:0]     disp_a_rd,
  input  logic [1:0]          disp_a_eu,
  input  logic                disp_b_valid,
  input  logic                disp_b_wb,
  input  logic [RD_W-1:0]     disp_b_rd,
  input  logic [1:0]          disp_b_eu,
  input  logic                alu_a_done,
  input  logic [RD_W-1:0]     alu_a_rd,
  input  logic                alu_b_done,
  input  logic [RD_W-1:0]     alu_b_rd,
  input  logic                ldst_done,
  output logic [NUM_REGS-1:0] mask_wr,
  output logic [NUM_REGS-1:0] mask_sat,
  output logic                mul_busy,
  output logic                ldst_busy,
  output logic                mul_wb_valid,
  output logic [RD_W-1:0]     mul_wb_rd
);

  // Countdown wide enough for latencies up to 15
  localparam int unsigned c_CD_W = 4;

  logic              w_a_mul, w_b_mul, w_mul_go, w_mul_wb_nxt;
  logic              w_a_ldst, w_b_ldst, w_ldst_go, w_ldst_wb_nxt, w_ldst_clr;
  logic [RD_W-1:0]   w_mul_rd_nxt, w_ldst_rd_nxt;
  logic [c_CD_W-1:0] r_mul_cd;
  logic [RD_W-1:0]   r_mul_rd;
  logic              r_mul_wb;
  logic              r_ldst_busy;
  reg_num_t          r_ldst_rd;
  logic              r_ldst_wb;
  hword_t            w_mask_wr;
  hword_t            w_mask_sat;

  // Decode sequenced-EU dispatches; slot A has priority on a double issue
  always_comb begin
    w_a_mul       = disp_a_valid && (eu_class_e'(disp_a_eu) == EU_MUL);
    w_b_mul       = disp_b_valid && (eu_class_e'(disp_b_eu) == EU_MUL);
    w_a_ldst      = disp_a_valid && (eu_class_e'(disp_a_eu) == EU_LDST);
    w_b_ldst      = disp_b_valid && (eu_class_e'(disp_b_eu) == EU_LDST);
    w_mul_go      = w_a_mul || w_b_mul;
    w_mul_rd_nxt  = w_a_mul ? disp_a_rd : disp_b_rd;
    w_mul_wb_nxt  = w_a_mul ? disp_a_wb : disp_b_wb;
    w_ldst_go     = w_a_ldst || w_b_ldst;
    w_ldst_rd_nxt = w_a_ldst ? disp_a_rd : disp_b_rd;
    w_ldst_wb_nxt = w_a_ldst ? disp_a_wb : disp_b_wb;
  end

  // Multiplier countdown; a reload may coincide with the final count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_cd <= '0;
      r_mul_rd <= '0;
      r_mul_wb <= 1'b0;
    end else if (w_mul_go) begin
      r_mul_cd <= c_CD_W'(MUL_LATENCY);
      r_mul_rd <= w_mul_rd_nxt;
      r_mul_wb <= w_mul_wb_nxt;
    end else if (r_mul_cd != '0) begin
      r_mul_cd <= r_mul_cd - c_CD_W'(1);
    end
  end

  // Ldst occupancy and destination latch; a new dispatch overrides done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ldst_busy <= 1'b0;
      r_ldst_rd   <= '0;
      r_ldst_wb   <= 1'b0;
    end else if (w_ldst_go) begin
      r_ldst_busy <= 1'b1;
      r_ldst_rd   <= w_ldst_rd_nxt;
      r_ldst_wb   <= w_ldst_wb_nxt;
    end else if (ldst_done) begin
      r_ldst_busy <= 1'b0;
    end
  end

  // EU status and writeback strobe derived from the sequencing state
  always_comb begin
    mul_busy     = (r_mul_cd != '0);
    mul_wb_valid = (r_mul_cd == c_CD_W'(1)) && r_mul_wb;
    mul_wb_rd    = r_mul_rd;
    ldst_busy    = r_ldst_busy;
    w_ldst_clr   = ldst_done && r_ldst_busy && r_ldst_wb;
  end

  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic       w_hit_a, w_hit_b;
      logic       w_clr_aa, w_clr_ab, w_clr_m, w_clr_l;
      logic [1:0] w_set_cnt;
      logic [2:0] w_clr_cnt;

      // Count sets and clears that target this register
      always_comb begin
        w_hit_a   = disp_a_valid && disp_a_wb && (disp_a_rd == RD_W'(r));
        w_hit_b   = disp_b_valid && disp_b_wb && (disp_b_rd == RD_W'(r));
        w_clr_aa  = alu_a_done && (alu_a_rd == RD_W'(r));
        w_clr_ab  = alu_b_done && (alu_b_rd == RD_W'(r));
        w_clr_m   = mul_wb_valid && (r_mul_rd == RD_W'(r));
        w_clr_l   = w_ldst_clr && (r_ldst_rd == RD_W'(r));
        w_set_cnt = {1'b0, w_hit_a} + {1'b0, w_hit_b};
        w_clr_cnt = {2'b00, w_clr_aa} + {2'b00, w_clr_ab}
                  + {2'b00, w_clr_m} + {2'b00, w_clr_l};
      end

      core_dispatch_scoreboard_cnt #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_cnt (w_set_cnt),
        .clr_cnt (w_clr_cnt),
        .busy    (w_mask_wr[r]),
        .sat     (w_mask_sat[r])
      );
    end
  endgenerate

  // Drive the hazard masks
  always_comb begin
    mask_wr  = w_mask_wr;
    mask_sat = w_mask_sat;
  end

  a_single_mul : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_a_mul && w_b_mul));
  a_single_ldst : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_a_ldst && w_b_ldst));

endmodule
`default_nettype wire

// File: tb/tb_core_dispatch_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_dispatch_scoreboard
//  Brief    : Directed self-checking bench for core_dispatch_scoreboard.
//             Inputs change 2 time units after each rising edge; registered
//             outputs are compared with all inputs idle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_dispatch_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_a_valid, disp_a_wb, disp_b_valid, disp_b_wb;
  logic [3:0]  disp_a_rd, disp_b_rd, alu_a_rd, alu_b_rd;
  logic [1:0]  disp_a_eu, disp_b_eu;
  logic        alu_a_done, alu_b_done, ldst_done;
  logic [15:0] mask_wr, mask_sat;
  logic        mul_busy, ldst_busy, mul_wb_valid;
  logic [3:0]  mul_wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_dispatch_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_a_valid (disp_a_valid),
    .disp_a_wb    (disp_a_wb),
    .disp_a_rd    (disp_a_rd),
    .disp_a_eu    (disp_a_eu),
    .disp_b_valid (disp_b_valid),
    .disp_b_wb    (disp_b_wb),
    .disp_b_rd    (disp_b_rd),
    .disp_b_eu    (disp_b_eu),
    .alu_a_done   (alu_a_done),
    .alu_a_rd     (alu_a_rd),
    .alu_b_done   (alu_b_done),
    .alu_b_rd     (alu_b_rd),
    .ldst_done    (ldst_done),
    .mask_wr      (mask_wr),
    .mask_sat     (mask_sat),
    .mul_busy     (mul_busy),
    .ldst_busy    (ldst_busy),
    .mul_wb_valid (mul_wb_valid),
    .mul_wb_rd    (mul_wb_rd)
  );

  task automatic idle_inputs();
    disp_a_valid = 0; disp_a_wb = 0; disp_a_rd = 0; disp_a_eu = 0;
    disp_b_valid = 0; disp_b_wb = 0; disp_b_rd = 0; disp_b_eu = 0;
    alu_a_done = 0; alu_a_rd = 0; alu_b_done = 0; alu_b_rd = 0;
    ldst_done = 0;
  endtask

  // Advance to the next cycle and return inputs to idle before checking
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
  endtask

  task automatic disp_a(input logic wb, input logic [3:0] rd, input logic [1:0] eu);
    disp_a_valid = 1; disp_a_wb = wb; disp_a_rd = rd; disp_a_eu = eu;
  endtask

  task automatic disp_b(input logic wb, input logic [3:0] rd, input logic [1:0] eu);
    disp_b_valid = 1; disp_b_wb = wb; disp_b_rd = rd; disp_b_eu = eu;
  endtask

  task automatic test_reset();
    if (mask_wr !== 16'h0000 || mul_busy !== 1'b0 || ldst_busy !== 1'b0 || mul_wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init got mask=%h mb=%b lb=%b wv=%b exp mask=0000 mb=0 lb=0 wv=0",
               mask_wr, mul_busy, ldst_busy, mul_wb_valid);
    end
    n_checks++;
    disp_a(1, 4'd5, 2'd0);
    disp_b(1, 4'd7, 2'd1);
    next_cycle();
    if (mask_wr !== 16'h00A0) begin
      n_fail++; $display("FAIL reset_pre_mask got=%h exp=%h", mask_wr, 16'h00A0);
    end
    n_checks++;
    if (mul_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_mulbusy got=%b exp=1", mul_busy);
    end
    n_checks++;
    #2 rst_n = 0;
    #1;
    if (mask_wr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_async_mask got=%h exp=0000", mask_wr);
    end
    n_checks++;
    if (mul_busy !== 1'b0 || mul_wb_valid !== 1'b0 || mul_wb_rd !== 4'd0) begin
      n_fail++; $display("FAIL reset_async_mul got busy=%b wv=%b rd=%0d exp 0/0/0",
                         mul_busy, mul_wb_valid, mul_wb_rd);
    end
    n_checks++;
    if (mask_sat !== 16'h0000 || ldst_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_sat got sat=%h lb=%b exp 0000/0", mask_sat, ldst_busy);
    end
    n_checks++;
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_ldst();
    next_cycle();
    disp_a(1, 4'd3, 2'd0);
    disp_b(1, 4'd3, 2'd2);
    next_cycle();
    if (mask_wr !== 16'h0008 || mask_sat !== 16'h0008 || ldst_busy !== 1'b1) begin
      n_fail++; $display("FAIL ldst_dual_set got mask=%h sat=%h lb=%b exp 0008/0008/1",
                         mask_wr, mask_sat, ldst_busy);
    end
    n_checks++;
    alu_a_done = 1; alu_a_rd = 4'd3;
    next_cycle();
    if (mask_wr !== 16'h0008 || mask_sat !== 16'h0000 || ldst_busy !== 1'b1) begin
      n_fail++; $display("FAIL ldst_after_alu got mask=%h sat=%h lb=%b exp 0008/0000/1",
                         mask_wr, mask_sat, ldst_busy);
    end
    n_checks++;
    ldst_done = 1;
    disp_b(1, 4'd6, 2'd2);
    next_cycle();
    if (mask_wr !== 16'h0040 || ldst_busy !== 1'b1) begin
      n_fail++; $display("FAIL ldst_done_redispatch got mask=%h lb=%b exp 0040/1", mask_wr, ldst_busy);
    end
    n_checks++;
    ldst_done = 1;
    next_cycle();
    if (mask_wr !== 16'h0000 || ldst_busy !== 1'b0) begin
      n_fail++; $display("FAIL ldst_done got mask=%h lb=%b exp 0000/0", mask_wr, ldst_busy);
    end
    n_checks++;
    ldst_done = 1;
    disp_a(1, 4'd6, 2'd0);
    next_cycle();
    if (mask_wr !== 16'h0040 || ldst_busy !== 1'b0) begin
      n_fail++; $display("FAIL ldst_done_idle_ignored got mask=%h lb=%b exp 0040/0", mask_wr, ldst_busy);
    end
    n_checks++;
    alu_a_done = 1; alu_a_rd = 4'd6;
    next_cycle();
    if (mask_wr !== 16'h0000) begin
      n_fail++; $display("FAIL ldst_cleanup got=%h exp=0000", mask_wr);
    end
    n_checks++;
  endtask

  task automatic test_mul_latency();
    logic [15:0] exp_c3;
`ifdef CORE_SB_BYPASS_EN
    exp_c3 = 16'h0000;
`else
    exp_c3 = 16'h0200;
`endif
    next_cycle();
    disp_a(1, 4'd9, 2'd1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      if (mul_busy !== 1'b1) begin
        n_fail++; $display("FAIL mul_busy_c%0d got=%b exp=1", c, mul_busy);
      end
      n_checks++;
      if (mul_wb_valid !== (c == 3)) begin
        n_fail++; $display("FAIL mul_wbv_c%0d got=%b exp=%b", c, mul_wb_valid, (c == 3));
      end
      n_checks++;
    end
    if (mul_wb_rd !== 4'd9 || mask_wr !== exp_c3) begin
      n_fail++; $display("FAIL mul_wb_c3 got rd=%0d mask=%h exp rd=9 mask=%h", mul_wb_rd, mask_wr, exp_c3);
    end
    n_checks++;
    next_cycle();
    if (mul_busy !== 1'b0 || mul_wb_valid !== 1'b0 || mask_wr !== 16'h0000) begin
      n_fail++; $display("FAIL mul_c4 got busy=%b wv=%b mask=%h exp 0/0/0000",
                         mul_busy, mul_wb_valid, mask_wr);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    next_cycle();
    disp_b(1, 4'd9, 2'd1);
    next_cycle();
    next_cycle();
    next_cycle();
    if (mul_wb_valid !== 1'b1 || mul_wb_rd !== 4'd9) begin
      n_fail++; $display("FAIL b2b_wb9 got wv=%b rd=%0d exp 1/9", mul_wb_valid, mul_wb_rd);
    end
    n_checks++;
    disp_a(1, 4'd2, 2'd1);
    next_cycle();
    if (mul_busy !== 1'b1 || mul_wb_valid !== 1'b0 || mask_wr !== 16'h0004) begin
      n_fail++; $display("FAIL b2b_reload got busy=%b wv=%b mask=%h exp 1/0/0004",
                         mul_busy, mul_wb_valid, mask_wr);
    end
    n_checks++;
    next_cycle();
    if (mul_busy !== 1'b1 || mul_wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_c5 got busy=%b wv=%b exp 1/0", mul_busy, mul_wb_valid);
    end
    n_checks++;
    next_cycle();
    if (mul_wb_valid !== 1'b1 || mul_wb_rd !== 4'd2) begin
      n_fail++; $display("FAIL b2b_wb2 got wv=%b rd=%0d exp 1/2", mul_wb_valid, mul_wb_rd);
    end
    n_checks++;
    next_cycle();
    if (mul_busy !== 1'b0 || mask_wr !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_done got busy=%b mask=%h exp 0/0000", mul_busy, mask_wr);
    end
    n_checks++;
  endtask

  task automatic test_saturation();
    next_cycle();
    disp_a(1, 4'd1, 2'd0);
    disp_b(1, 4'd1, 2'd3);
    next_cycle();
    if (mask_sat !== 16'h0002 || mask_wr !== 16'h0002) begin
      n_fail++; $display("FAIL sat_set got sat=%h mask=%h exp 0002/0002", mask_sat, mask_wr);
    end
    n_checks++;
    disp_a(1, 4'd1, 2'd0);
    disp_b(1, 4'd1, 2'd0);
    alu_a_done = 1; alu_a_rd = 4'd1;
    alu_b_done = 1; alu_b_rd = 4'd1;
    next_cycle();
    if (mask_sat !== 16'h0002 || mask_wr !== 16'h0002) begin
      n_fail++; $display("FAIL sat_net_zero got sat=%h mask=%h exp 0002/0002", mask_sat, mask_wr);
    end
    n_checks++;
    alu_a_done = 1; alu_a_rd = 4'd1;
    next_cycle();
    if (mask_sat !== 16'h0000 || mask_wr !== 16'h0002) begin
      n_fail++; $display("FAIL sat_below got sat=%h mask=%h exp 0000/0002", mask_sat, mask_wr);
    end
    n_checks++;
    alu_b_done = 1; alu_b_rd = 4'd1;
    next_cycle();
    if (mask_sat !== 16'h0000 || mask_wr !== 16'h0000) begin
      n_fail++; $display("FAIL sat_empty got sat=%h mask=%h exp 0000/0000", mask_sat, mask_wr);
    end
    n_checks++;
  endtask

  task automatic test_same_cycle();
    next_cycle();
    disp_a(1, 4'd4, 2'd0);
    next_cycle();
    if (mask_wr !== 16'h0010) begin
      n_fail++; $display("FAIL same_pre got=%h exp=0010", mask_wr);
    end
    n_checks++;
    disp_a(1, 4'd4, 2'd0);
    alu_b_done = 1; alu_b_rd = 4'd4;
    next_cycle();
    if (mask_wr !== 16'h0010 || mask_sat !== 16'h0000) begin
      n_fail++; $display("FAIL same_net got mask=%h sat=%h exp 0010/0000", mask_wr, mask_sat);
    end
    n_checks++;
    alu_a_done = 1; alu_a_rd = 4'd4;
    next_cycle();
    if (mask_wr !== 16'h0000) begin
      n_fail++; $display("FAIL same_cleanup got=%h exp=0000", mask_wr);
    end
    n_checks++;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    test_reset();
    test_ldst();
    test_mul_latency();
    test_back_to_back();
    test_saturation();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
